// File: rtl/draw_glyph_pkg.sv
// Shared state encoding, request record and default geometry for the glyph blitter.
package draw_glyph_pkg;

  localparam int DEF_GLYPH_W  = 8;
  localparam int DEF_GLYPH_H  = 16;
  localparam int DEF_STRIDE   = 320;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_BASELINE = 8;

  localparam logic [6:0] CODE_SOLID = 7'h7f;
  localparam logic [6:0] CODE_CHECK = 7'h01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y0;
    logic [6:0] code;
    logic       scale;
    logic [7:0] fg;
    logic [7:0] bg;
    logic       trans;
  } req_t;

  // Font content: a solid block, a checkerboard, and an arithmetic pattern for the rest.
  function automatic logic glyph_pixel(input logic [6:0] code, input int r, input int c);
    logic [7:0] rb;
    rb = 8'(int'(code) * (r + 1));
    if (code == CODE_SOLID) return 1'b1;
    if (code == CODE_CHECK) return ~(r[0] ^ c[0]);
    return rb[3'(7 - c)];
  endfunction

endpackage

// File: rtl/draw_glyph_rom.sv
// Character ROM: one row-major glyph bitmap per code, registered one-cycle read.
module char_rom
  import draw_glyph_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H
) (
  input  logic                       clk25_i,
  input  logic                       rst_i,
  input  logic [6:0]                 code_i,
  output logic [GLYPH_W*GLYPH_H-1:0] data_o
);

  localparam int PIX = GLYPH_W * GLYPH_H;

  logic [PIX-1:0] data_d, data_q;

  // Shifting pixels in row-major order leaves pixel (0,0) in the MSB.
  always_comb begin
    data_d = '0;
    for (int r = 0; r < GLYPH_H; r++)
      for (int c = 0; c < GLYPH_W; c++)
        data_d = {data_d[PIX-2:0], glyph_pixel(code_i, r, c)};
  end

  always_ff @(posedge clk25_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/draw_glyph.sv
// Glyph blitter: renders one character into a 16-bit, two-pixels-per-word SRAM framebuffer.
module draw_glyph
  import draw_glyph_pkg::*;
#(
  parameter int GLYPH_W  = DEF_GLYPH_W,
  parameter int GLYPH_H  = DEF_GLYPH_H,
  parameter int STRIDE   = DEF_STRIDE,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BASELINE = DEF_BASELINE
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  x_from,
  input  logic [9:0]  y_from,
  input  logic [6:0]  code,
  input  logic        scale,
  input  logic [7:0]  fg,
  input  logic [7:0]  bg,
  input  logic        transparent,
  input  logic        grant,
  output logic        busy,
  output logic        done,
  output wire  [19:0] SRAM_ADDR,
  output wire  [15:0] SRAM_DQ,
  output wire         SRAM_CE_N,
  output wire         SRAM_OE_N,
  output wire         SRAM_WE_N,
  output wire         SRAM_UB_N,
  output wire         SRAM_LB_N
);

  localparam int PIX = GLYPH_W * GLYPH_H;
  localparam int IW  = $clog2(PIX);
  localparam int RW  = $clog2(2 * GLYPH_H);
  localparam int WW  = $clog2(GLYPH_W + 2);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [RW-1:0]   row_q, row_d;
  logic [WW-1:0]   word_q, word_d;
  logic [PIX-1:0]  rom_q;
  logic [1:0]      lane_en;
  logic [1:0][7:0] lane_px;
  logic [19:0]     addr;
  logic            strobe, y_ok;
  int              n_words, n_rows, span, glyph_r, scr_y, word_x;

  char_rom #(.GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H)) u_rom (
    .clk25_i (clk25),
    .rst_i   (rst),
    .code_i  (req_q.code),
    .data_o  (rom_q)
  );

  // Geometry of the word under the row/word counters; rows are not wrapped, so a
  // top row above the screen lands past SCREEN_H and is clipped.
  always_comb begin
    span    = req_q.scale ? 2 * GLYPH_W : GLYPH_W;
    n_rows  = req_q.scale ? 2 * GLYPH_H : GLYPH_H;
    n_words = (int'(req_q.x[0]) + span + 1) >> 1;
    glyph_r = req_q.scale ? int'(row_q) >> 1 : int'(row_q);
    scr_y   = int'(req_q.y0) + int'(row_q);
    word_x  = int'(req_q.x[9:1]) + int'(word_q);
    y_ok    = scr_y < SCREEN_H;
    addr    = 20'(scr_y * STRIDE + word_x);
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    int             scr_x, dx;
    logic [IW-1:0]  idx;
    logic [PIX-1:0] sh;
    logic           pix, in_box;
    always_comb begin
      scr_x  = 2 * word_x + l;
      dx     = scr_x - int'(req_q.x);
      idx    = IW'(glyph_r * GLYPH_W + (req_q.scale ? dx >>> 1 : dx));
      sh     = rom_q << idx;
      pix    = sh[PIX-1];
      in_box = (dx >= 0) && (dx < span) && (scr_x < SCREEN_W) && y_ok;
    end
    assign lane_px[l] = pix ? req_q.fg : req_q.bg;
    assign lane_en[l] = in_box && (pix || !req_q.trans);
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    row_d   = row_q;
    word_d  = word_q;
    strobe  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_LOAD;
        req_d.x     = x_from;
        req_d.y0    = y_from - 10'(BASELINE);
        req_d.code  = code;
        req_d.scale = scale;
        req_d.fg    = fg;
        req_d.bg    = bg;
        req_d.trans = transparent;
        row_d       = '0;
        word_d      = '0;
      end
      S_LOAD: state_d = S_DRAW;
      // A word slot is spent whether or not any lane writes; no grant, no progress.
      S_DRAW: if (grant) begin
        strobe = |lane_en;
        if (int'(word_q) == n_words - 1) begin
          word_d = '0;
          if (int'(row_q) == n_rows - 1) state_d = S_DONE;
          else                           row_d   = row_q + RW'(1);
        end else begin
          word_d = word_q + WW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      row_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      row_q   <= row_d;
      word_q  <= word_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // WE_N tracks the clock so the write pulse sits in the low half of the cycle.
  assign SRAM_ADDR = strobe ? addr        : 'z;
  assign SRAM_DQ   = strobe ? lane_px     : 'z;
  assign SRAM_CE_N = strobe ? 1'b0        : 1'bz;
  assign SRAM_OE_N = strobe ? 1'b1        : 1'bz;
  assign SRAM_WE_N = strobe ? clk25       : 1'bz;
  assign SRAM_UB_N = strobe ? ~lane_en[1] : 1'bz;
  assign SRAM_LB_N = strobe ? ~lane_en[0] : 1'bz;

endmodule

// File: tb/tb_draw_glyph.sv
// Randomized bench for draw_glyph against a pixel-level framebuffer write model.
module tb_draw_glyph;

  logic       clk25 = 1'b0;
  logic       rst, start, scale, transparent, grant;
  logic [9:0] x_from, y_from;
  logic [6:0] code;
  logic [7:0] fg, bg;
  logic       busy, done;
  wire [19:0] SRAM_ADDR;
  wire [15:0] SRAM_DQ;
  wire        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  pullup (SRAM_CE_N);
  pullup (SRAM_OE_N);
  pullup (SRAM_WE_N);
  pullup (SRAM_UB_N);
  pullup (SRAM_LB_N);

  int checks = 0, failures = 0;

  typedef struct { int addr; int dq; int be; } wr_t;
  wr_t exp_q[$];

  always #20 clk25 = ~clk25;

  draw_glyph dut (
    .clk25(clk25), .rst(rst), .start(start), .x_from(x_from), .y_from(y_from),
    .code(code), .scale(scale), .fg(fg), .bg(bg), .transparent(transparent),
    .grant(grant), .busy(busy), .done(done),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  task automatic tb_chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int gbit(int cd, int r, int c);
    if (cd == 127) return 1;
    if (cd == 1)   return ((r + c) % 2 == 0) ? 1 : 0;
    return (((cd * (r + 1)) & 255) >> (7 - c)) & 1;
  endfunction

  // Expected write list: scan every word slot, keep those with an enabled lane.
  function automatic int build(int x, int y, int cd, int sc, int f, int b, int t);
    int s, n, y0, sy, sx, dx, be, dq, p;
    wr_t w;
    exp_q.delete();
    s  = sc ? 2 : 1;
    n  = (x % 2 + 8 * s + 1) / 2;
    y0 = (y - 8) & 1023;
    for (int j = 0; j < 16 * s; j++)
      for (int k = 0; k < n; k++) begin
        sy = y0 + j; be = 0; dq = 0;
        for (int l = 0; l < 2; l++) begin
          sx = 2 * (x / 2 + k) + l;
          dx = sx - x;
          if (dx >= 0 && dx < 8 * s && sx < 640 && sy < 480) begin
            p = gbit(cd, j / s, dx / s);
            if (p == 1 || t == 0) begin
              be |= 1 << l;
              dq |= (p == 1 ? f : b) << (8 * l);
            end
          end
        end
        if (be != 0) begin
          w.addr = sy * 320 + x / 2 + k; w.dq = dq; w.be = be;
          exp_q.push_back(w);
        end
      end
    return 16 * s * n;
  endfunction

  task automatic run(input string tag, input int x, input int y, input int cd, input int sc,
                     input int f, input int b, input int t, input int gmode, input int rst_at,
                     output int nwr, output int first_addr, output int lat);
    int total, cyc, gbe, gdq;
    bit fin;
    wr_t e;
    total = build(x, y, cd, sc, f, b, t);
    @(negedge clk25);
    x_from = 10'(x); y_from = 10'(y); code = 7'(cd); scale = 1'(sc);
    fg = 8'(f); bg = 8'(b); transparent = 1'(t); grant = 1'b1; start = 1'b1;
    nwr = 0; first_addr = -1; lat = -1; cyc = 0; fin = 0;
    while (!fin) begin
      @(negedge clk25);
      cyc++;
      start = 1'($urandom_range(0, 1));
      x_from = 10'($urandom); y_from = 10'($urandom); code = 7'($urandom);
      scale = 1'($urandom); fg = 8'($urandom); bg = 8'($urandom); transparent = 1'($urandom);
      case (gmode)
        0:       grant = 1'b1;
        1:       grant = ((cyc / 3) % 2) == 0;
        default: grant = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == rst_at) rst = 1'b1;
      #1;
      if (SRAM_CE_N === 1'b0 && SRAM_WE_N === 1'b0) begin
        nwr++;
        tb_chk({tag, "_wr_grant"}, grant, 1);
        tb_chk({tag, "_oe_n"}, SRAM_OE_N, 1);
        if (exp_q.size() == 0) tb_chk({tag, "_extra_wr"}, nwr, 0);
        else begin
          e = exp_q.pop_front();
          gbe = {30'd0, ~SRAM_UB_N, ~SRAM_LB_N};
          gdq = 0;
          if (!SRAM_LB_N) gdq |= int'(SRAM_DQ[7:0]);
          if (!SRAM_UB_N) gdq |= int'(SRAM_DQ[15:8]) << 8;
          if (first_addr < 0) first_addr = int'(SRAM_ADDR);
          tb_chk({tag, "_addr"}, SRAM_ADDR, e.addr);
          tb_chk({tag, "_be"}, gbe, e.be);
          tb_chk({tag, "_dq"}, gdq, e.dq);
        end
      end
      if (done === 1'b1) begin lat = cyc; fin = 1; end
      if (cyc == rst_at) fin = 1;
      if (cyc > 3000) begin tb_chk({tag, "_timeout"}, cyc, 0); fin = 1; end
    end
    start = 1'b0;
    if (rst_at > 0) begin
      @(negedge clk25); #1;
      tb_chk({tag, "_busy_after_rst"}, busy, 0);
      tb_chk({tag, "_done_after_rst"}, done, 0);
      tb_chk({tag, "_ce_after_rst"}, SRAM_CE_N, 1);
      tb_chk({tag, "_we_after_rst"}, SRAM_WE_N, 1);
      rst = 1'b0;
      exp_q.delete();
    end else begin
      tb_chk({tag, "_missing_wr"}, exp_q.size(), 0);
      if (gmode == 0) tb_chk({tag, "_latency"}, lat, 2 + total);
    end
  endtask

  initial begin
    int nwr, fa, lat;
    rst = 1'b1; start = 1'b0; grant = 1'b0; x_from = '0; y_from = '0; code = '0;
    scale = 1'b0; fg = '0; bg = '0; transparent = 1'b0;
    repeat (3) @(negedge clk25);
    #1;
    tb_chk("rst_busy", busy, 0);
    tb_chk("rst_done", done, 0);
    tb_chk("rst_ce_n", SRAM_CE_N, 1);
    tb_chk("rst_we_n", SRAM_WE_N, 1);
    rst = 1'b0;

    run("solid", 100, 50, 127, 0, 8'hff, $urandom_range(0, 255), 0, 0, 0, nwr, fa, lat);
    tb_chk("solid_nwr", nwr, 64);
    tb_chk("solid_addr0", fa, 13490);
    tb_chk("solid_lat", lat, 66);

    run("odd", 101, 50, 127, 0, 8'hff, 8'h12, 0, 0, 0, nwr, fa, lat);
    tb_chk("odd_nwr", nwr, 80);
    tb_chk("odd_lat", lat, 82);

    run("checker", 37, 200, 1, 0, 8'ha5, 8'h00, 1, 0, 0, nwr, fa, lat);
    tb_chk("checker_nwr", nwr, 64);

    run("x2", 0, 8, $urandom_range(2, 126), 1, 8'h3c, 8'hc3, 0, 0, 0, nwr, fa, lat);
    tb_chk("x2_lat", lat, 258);

    run("clip_top", 636, 4, 127, 0, 8'h77, 8'h11, 0, 0, 0, nwr, fa, lat);
    tb_chk("clip_top_nwr", nwr, 0);
    tb_chk("clip_top_lat", lat, 66);

    run("clip_right", 636, 20, 127, 1, 8'h77, 8'h11, 0, 0, 0, nwr, fa, lat);
    tb_chk("clip_right_nwr", nwr, 64);

    for (int i = 0; i < 6; i++)
      run("rand", $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 127),
          $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 1), (i < 2) ? 0 : 2, 0, nwr, fa, lat);

    run("toggle_rst", 100, 50, 127, 0, 8'hff, 8'h00, 0, 1, 40, nwr, fa, lat);
    tb_chk("toggle_rst_partial", (nwr > 0 && nwr < 64) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
